// File: rtl/mini_mips_core.sv
// Multi-cycle ADDIU/ADDU/SUBU engine: FETCH/DECODE/EXEC/WB, halts after PROG_LEN instructions.
// Define MINI_MIPS_ILLEGAL_TRAP_EN to trap unrecognised instructions instead of treating them as NOPs.
module mini_mips_core #(
    parameter int PROG_LEN = 7,
    parameter int PC_W     = 3
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     instruction,
    input  logic [4:0]      dbg_addr,
    output logic [31:0]     dbg_data,
    output logic [2:0]      state_o,
    output logic            done,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] res;
    logic [4:0]  dest;
    logic        wen;
    logic        is_sub;
    logic [31:0] regs [0:31];

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        is_addiu;
    logic        is_addu;
    logic        is_subu;
    logic        legal;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_sext;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_addiu = 1'b0;
        is_addu  = 1'b0;
        is_subu  = 1'b0;
        if (opcode == OP_ADDIU) begin
            is_addiu = 1'b1;
        end else if (opcode == OP_RTYPE) begin
            is_addu = (funct == FN_ADDU);
            is_subu = (funct == FN_SUBU);
        end
        legal = is_addiu | is_addu | is_subu;
    end

    // Register 0 is never written, but reads are forced to zero explicitly anyway.
    assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];
    assign state_o  = state;

`ifndef MINI_MIPS_ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= '0;
            done   <= 1'b0;
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
            dest   <= '0;
            wen    <= 1'b0;
            is_sub <= 1'b0;
`ifdef MINI_MIPS_ILLEGAL_TRAP_EN
            illegal <= 1'b0;
`endif
            // NOTE: the register file must clear on reset, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < 32; i++) begin
                regs[i[4:0]] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= instruction;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    opa    <= rs_val;
                    opb    <= is_addiu ? imm_sext : rt_val;
                    dest   <= is_addiu ? rt : rd;
                    is_sub <= is_subu;
                    wen    <= legal;
`ifdef MINI_MIPS_ILLEGAL_TRAP_EN
                    if (!legal) begin
                        illegal <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
`else
                    state <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    res   <= is_sub ? (opa - opb) : (opa + opb);
                    state <= S_WB;
                end
                S_WB: begin
                    if (wen && dest != 5'd0) begin
                        regs[dest] <= res;
                    end
                    if (pc == PC_W'(PROG_LEN - 1)) begin
                        done  <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        pc    <= pc + PC_W'(1);
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule
